imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Upstream feeder for the 32x32 instruction SRAM's initialization port.
//  Accepts a byte stream over a valid/ready handshake and packs bytes little-endian into 32-bit words.
//  Writes WORD_COUNT consecutive words starting at address 0, then releases the SRAM for normal fetch.
//  SRAM contract: while chip_enable=0 it writes memory[init_addr]<=init_data on every clk edge.
// PARAMETERS
//  ADDR_W      5   SRAM address width
//  WORD_COUNT  32  words per load, 1..2**ADDR_W
// PORTS
//  clk          in   1       sole clock, all logic on posedge
//  rst          in   1       synchronous reset, active-high
//  start        in   1       one-cycle request to begin a load
//  byte_valid   in   1       upstream byte available
//  byte_data    in   8       upstream byte
//  byte_ready   out  1       loader accepts a byte; transfer occurs when byte_valid & byte_ready
//  chip_enable  out  1       to SRAM: 0=init writes active, 1=normal read
//  init_addr    out  ADDR_W  to SRAM init address, registered
//  init_data    out  32      to SRAM init data, registered
//  busy         out  1       load in progress: any state except IDLE and DONE
//  done         out  1       load finished, sticky until next start or rst
//  cksum_err    out  1       checksum mismatch, sticky; driven 0 when macro absent
// BEHAVIOUR
//  Clock/reset: one clock; reset is synchronous and active-high.
//  Reset values: state=IDLE, chip_enable=1, init_addr=0, init_data=0, byte_ready=0, busy=0, done=0, cksum_err=0.
//  Reset also clears: byte counter, word counter, assembly register, checksum accumulator.
//  States:
//   IDLE:  chip_enable=1, byte_ready=0. start -> LOAD. Also clears counters, done, cksum_err, init_addr=0.
//   LOAD:  chip_enable=0, byte_ready=1.
//          Each handshake shifts asm <= {byte_data, asm[31:8]}; byte_cnt increments mod 4.
//          On the 4th byte, in the same edge: init_data <= {byte_data, asm[31:8]}, init_addr <= word_idx, word_idx++.
//          SRAM captures that word on the following edge.
//          After the word with word_idx = WORD_COUNT-1 is registered -> FLUSH.
//   FLUSH: chip_enable=0, byte_ready=0, exactly 1 cycle so the last word is written.
//          Then -> CHECK if macro is defined, else -> DONE.
//   DONE:  chip_enable=1, byte_ready=0, done=1. start -> LOAD; done and cksum_err clear and counters reset on that edge.
//  Handshake: a byte is consumed only when valid & ready. Upstream stalls (valid=0) insert idle cycles; no data is lost.
//  Write side effects while chip_enable=0: the SRAM rewrites the currently registered addr/data every cycle.
//   Before word 0 completes, memory[0] is transiently written 0; it is then overwritten. This is accepted behaviour.
//  start while busy=1 is ignored. Bytes offered in IDLE or DONE are not accepted.
//  word_idx counter is $clog2(WORD_COUNT+1) bits wide; init_addr takes its low ADDR_W bits.
//  rst mid-load: state returns to IDLE on the next edge and chip_enable goes to 1. The partial word is discarded.
//   Words already written remain in the SRAM.
// CONFIGURATION
//  IMEM_LOADER_CHECKSUM_EN defined:
//   - Each data byte is added to an 8-bit accumulator (mod 256).
//   - FLUSH -> CHECK. CHECK holds chip_enable=0 and byte_ready=1 and accepts exactly one checksum byte.
//   - Check rule: if (acc + checksum byte) mod 256 != 0, set cksum_err=1. Then -> DONE either way.
//  Macro absent:
//   - No CHECK state and no accumulator; cksum_err is tied 0.
// TESTING
//  1. rst=1 for 2 cycles -> all outputs at reset values; chip_enable=1; byte_ready=0.
//  2. start, 128 bytes 0x00..0x7F with no stalls -> memory[0]=0x03020100, memory[31]=0x7F7E7D7C; done=1; busy=0; chip_enable=1.
//  3. Same as 2 with byte_valid toggling every cycle -> identical SRAM contents; done asserted 128 cycles later than in 2.
//  4. start pulsed again at byte 40 -> ignored; load completes normally; start pulsed in DONE -> new load begins, done=0.
//  5. rst asserted after byte 6 -> next cycle state=IDLE and chip_enable=1. Restarted load writes memory[1] from new bytes only.
//  6. (macro) 128 bytes of 0x01, then checksum 0x80 -> cksum_err=0; checksum 0x81 -> cksum_err=1; done=1 in both cases.

Source files
------------

// File: rtl/imem_loader.sv
// Byte-stream loader for the instruction SRAM init port: packs bytes little-endian into words and writes WORD_COUNT words from address 0.
// Optional trailing checksum byte check is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned WORD_COUNT = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              chip_enable,
    output logic [ADDR_W-1:0] init_addr,
    output logic [31:0]       init_data,
    output logic              busy,
    output logic              done,
    output logic              cksum_err
);

    localparam int unsigned IDX_W = $clog2(WORD_COUNT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_COUNT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_FLUSH = 3'd2,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHECK = 3'd4,
`endif
        S_DONE  = 3'd3
    } state_t;

    state_t           state;
    logic [1:0]       byte_cnt;
    logic [IDX_W-1:0] word_idx;
    logic [31:0]      asm_word;
    logic             xfer;
    logic [31:0]      next_word;

    assign xfer      = byte_valid & byte_ready;
    assign next_word = {byte_data, asm_word[31:8]};

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] acc;
`else
    assign cksum_err = 1'b0;
`endif

    // Single-process FSM; every output is registered and updated on the transition into its state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            chip_enable <= 1'b1;
            byte_ready  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            init_addr   <= '0;
            init_data   <= '0;
            byte_cnt    <= '0;
            word_idx    <= '0;
            asm_word    <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            acc         <= '0;
            cksum_err   <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    chip_enable <= 1'b1;
                    byte_ready  <= 1'b0;
                    busy        <= 1'b0;
                    done        <= 1'b0;
                    init_addr   <= '0;
                    byte_cnt    <= '0;
                    word_idx    <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    acc         <= '0;
                    cksum_err   <= 1'b0;
`endif
                    if (start) begin
                        state       <= S_LOAD;
                        chip_enable <= 1'b0;
                        byte_ready  <= 1'b1;
                        busy        <= 1'b1;
                        init_data   <= '0;
                    end
                end

                S_LOAD: begin
                    if (xfer) begin
                        asm_word <= next_word;
                        byte_cnt <= byte_cnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        acc      <= 8'(acc + byte_data);
`endif
                        // Fourth byte completes a word; SRAM captures it on the next edge.
                        if (byte_cnt == 2'd3) begin
                            init_data <= next_word;
                            init_addr <= ADDR_W'(word_idx);
                            word_idx  <= word_idx + IDX_W'(1);
                            if (word_idx == LAST_IDX) begin
                                state      <= S_FLUSH;
                                byte_ready <= 1'b0;
                            end
                        end
                    end
                end

                S_FLUSH: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state       <= S_CHECK;
                    byte_ready  <= 1'b1;
`else
                    state       <= S_DONE;
                    chip_enable <= 1'b1;
                    busy        <= 1'b0;
                    done        <= 1'b1;
`endif
                end

`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CHECK: begin
                    if (xfer) begin
                        if (8'(acc + byte_data) != 8'd0) begin
                            cksum_err <= 1'b1;
                        end
                        state       <= S_DONE;
                        chip_enable <= 1'b1;
                        byte_ready  <= 1'b0;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                    end
                end
`endif

                S_DONE: begin
                    if (start) begin
                        state       <= S_LOAD;
                        chip_enable <= 1'b0;
                        byte_ready  <= 1'b1;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        init_addr   <= '0;
                        init_data   <= '0;
                        byte_cnt    <= '0;
                        word_idx    <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        acc         <= '0;
                        cksum_err   <= 1'b0;
`endif
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a behavioural model of the SRAM init port.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_ready;
    logic        chip_enable;
    logic [4:0]  init_addr;
    logic [31:0] init_data;
    logic        busy;
    logic        done;
    logic        cksum_err;

    int          cyc = 0;
    int          n_pass = 0;
    int          n_total = 0;
    int          base_lat = 0;
    logic [7:0]  sum;
    logic        mem_clr = 1'b0;
    logic [31:0] mem [32];

    imem_loader #(.ADDR_W(5), .WORD_COUNT(32)) dut (
        .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid),
        .byte_data(byte_data), .byte_ready(byte_ready), .chip_enable(chip_enable),
        .init_addr(init_addr), .init_data(init_data), .busy(busy), .done(done),
        .cksum_err(cksum_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // SRAM init-port behaviour
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int k = 0; k < 32; k++) mem[k] <= 32'h0;
        end else if (!chip_enable) begin
            mem[init_addr] <= init_data;
        end
    end

    function automatic logic [31:0] exp_word(input logic [7:0] base, input logic [7:0] step, input int k);
        logic [7:0] b [4];
        for (int j = 0; j < 4; j++) b[j] = base + 8'(4 * k + j) * step;
        return {b[3], b[2], b[1], b[0]};
    endfunction

    function automatic int count_bad(input logic [7:0] base, input logic [7:0] step);
        int bad = 0;
        for (int k = 0; k < 32; k++) if (mem[k] !== exp_word(base, step, k)) bad++;
        return bad;
    endfunction

    task automatic do_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic clear_mem();
        @(negedge clk); mem_clr = 1'b1;
        @(negedge clk); mem_clr = 1'b0;
    endtask

    task automatic stream(input int n, input logic [7:0] base, input logic [7:0] step,
                          input bit stall, input int pulse_at, output bit ok);
        int i = 0;
        int guard = 0;
        bit ph = 1'b0;
        bit v;
        bit pulsed = 1'b0;
        sum = 8'h00;
        while (i < n && guard < 4000) begin
            @(negedge clk);
            guard++;
            v = stall ? ph : 1'b1;
            ph = ~ph;
            start = (i == pulse_at) && !pulsed;
            if (start) pulsed = 1'b1;
            byte_valid = v;
            byte_data  = base + 8'(i) * step;
            if (v && byte_ready) begin
                sum = sum + byte_data;
                i++;
            end
        end
        @(negedge clk);
        byte_valid = 1'b0;
        start = 1'b0;
        ok = (i == n);
    endtask

    task automatic send_byte(input logic [7:0] b, output bit ok);
        int guard = 0;
        ok = 1'b0;
        while (!ok && guard < 100) begin
            @(negedge clk);
            guard++;
            byte_valid = 1'b1;
            byte_data  = b;
            if (byte_ready) ok = 1'b1;
        end
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic finish_load(output bit ok);
        ok = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'(8'h00 - sum), ok);
`endif
    endtask

    task automatic wait_done(output bit ok);
        int guard = 0;
        while (done !== 1'b1 && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        ok = (done === 1'b1);
    endtask

    task automatic full_load(input logic [7:0] base, input bit stall, input int pulse_at,
                             output int lat, output bit ok);
        int t0;
        bit ok1, ok2, ok3;
        do_start();
        t0 = cyc;
        stream(128, base, 8'd1, stall, pulse_at, ok1);
        finish_load(ok2);
        wait_done(ok3);
        lat = cyc - t0;
        ok = ok1 && ok2 && ok3;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_total++; if (chip_enable !== 1'b1) $display("FAIL reset_ce: got %b want 1", chip_enable); else n_pass++;
        n_total++; if (byte_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", byte_ready); else n_pass++;
        n_total++; if (init_addr !== 5'd0) $display("FAIL reset_addr: got %h want 00", init_addr); else n_pass++;
        n_total++; if (init_data !== 32'h0) $display("FAIL reset_data: got %h want 0", init_data); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
        n_total++; if (cksum_err !== 1'b0) $display("FAIL reset_cksum: got %b want 0", cksum_err); else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_load_no_stall();
        bit ok;
        full_load(8'h00, 1'b0, -1, base_lat, ok);
        n_total++; if (!ok) $display("FAIL load_timeout: got 0 want 1"); else n_pass++;
        n_total++; if (mem[0] !== 32'h03020100) $display("FAIL load_mem0: got %h want 03020100", mem[0]); else n_pass++;
        n_total++; if (mem[17] !== 32'h47464544) $display("FAIL load_mem17: got %h want 47464544", mem[17]); else n_pass++;
        n_total++; if (mem[31] !== 32'h7F7E7D7C) $display("FAIL load_mem31: got %h want 7f7e7d7c", mem[31]); else n_pass++;
        n_total++; if (done !== 1'b1 || busy !== 1'b0 || chip_enable !== 1'b1 || byte_ready !== 1'b0)
            $display("FAIL load_status: got done=%b busy=%b ce=%b rdy=%b want 1 0 1 0", done, busy, chip_enable, byte_ready);
        else n_pass++;
        n_total++; if (cksum_err !== 1'b0) $display("FAIL load_cksum: got %b want 0", cksum_err); else n_pass++;
    endtask

    task automatic test_load_stall();
        bit ok;
        int lat;
        int bad;
        clear_mem();
        full_load(8'h00, 1'b1, -1, lat, ok);
        bad = count_bad(8'h00, 8'd1);
        n_total++; if (!ok) $display("FAIL stall_timeout: got 0 want 1"); else n_pass++;
        n_total++; if (bad !== 0) $display("FAIL stall_mem: got %0d bad words want 0", bad); else n_pass++;
        n_total++; if (lat !== base_lat + 128) $display("FAIL stall_latency: got %0d want %0d", lat, base_lat + 128); else n_pass++;
        n_total++; if (done !== 1'b1) $display("FAIL stall_done: got %b want 1", done); else n_pass++;
    endtask

    task automatic test_start_ignored();
        bit ok;
        int lat;
        int bad;
        full_load(8'h80, 1'b0, 40, lat, ok);
        bad = count_bad(8'h80, 8'd1);
        n_total++; if (!ok) $display("FAIL restart_timeout: got 0 want 1"); else n_pass++;
        n_total++; if (lat !== base_lat) $display("FAIL restart_latency: got %0d want %0d", lat, base_lat); else n_pass++;
        n_total++; if (bad !== 0) $display("FAIL restart_mem: got %0d bad words want 0", bad); else n_pass++;
        n_total++; if (mem[0] !== 32'h83828180) $display("FAIL restart_mem0: got %h want 83828180", mem[0]); else n_pass++;
        do_start();
        n_total++; if (done !== 1'b0 || busy !== 1'b1 || chip_enable !== 1'b0 || byte_ready !== 1'b1)
            $display("FAIL done_start: got done=%b busy=%b ce=%b rdy=%b want 0 1 0 1", done, busy, chip_enable, byte_ready);
        else n_pass++;
        stream(128, 8'h00, 8'd1, 1'b0, -1, ok);
        finish_load(ok);
        wait_done(ok);
        n_total++; if (!ok) $display("FAIL done_start_finish: got 0 want 1"); else n_pass++;
    endtask

    task automatic test_rst_mid_load();
        bit ok;
        int lat;
        do_start();
        stream(6, 8'h40, 8'd1, 1'b0, -1, ok);
        rst = 1'b1;
        @(negedge clk);
        n_total++; if (chip_enable !== 1'b1 || busy !== 1'b0 || byte_ready !== 1'b0)
            $display("FAIL midrst_status: got ce=%b busy=%b rdy=%b want 1 0 0", chip_enable, busy, byte_ready);
        else n_pass++;
        n_total++; if (mem[0] !== 32'h43424140) $display("FAIL midrst_mem0: got %h want 43424140", mem[0]); else n_pass++;
        n_total++; if (mem[1] !== 32'h07060504) $display("FAIL midrst_mem1_kept: got %h want 07060504", mem[1]); else n_pass++;
        rst = 1'b0;
        full_load(8'hC0, 1'b0, -1, lat, ok);
        n_total++; if (!ok) $display("FAIL midrst_timeout: got 0 want 1"); else n_pass++;
        n_total++; if (mem[1] !== 32'hC7C6C5C4) $display("FAIL midrst_mem1: got %h want c7c6c5c4", mem[1]); else n_pass++;
        n_total++; if (mem[0] !== 32'hC3C2C1C0) $display("FAIL midrst_mem0_new: got %h want c3c2c1c0", mem[0]); else n_pass++;
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        bit ok1, ok2, ok3;
        do_start();
        stream(128, 8'h01, 8'd0, 1'b0, -1, ok1);
        send_byte(8'h80, ok2);
        wait_done(ok3);
        n_total++; if (!(ok1 && ok2 && ok3)) $display("FAIL cksum_good_timeout: got 0 want 1"); else n_pass++;
        n_total++; if (cksum_err !== 1'b0 || done !== 1'b1)
            $display("FAIL cksum_good: got err=%b done=%b want 0 1", cksum_err, done);
        else n_pass++;
        do_start();
        stream(128, 8'h01, 8'd0, 1'b0, -1, ok1);
        send_byte(8'h81, ok2);
        wait_done(ok3);
        n_total++; if (!(ok1 && ok2 && ok3)) $display("FAIL cksum_bad_timeout: got 0 want 1"); else n_pass++;
        n_total++; if (cksum_err !== 1'b1 || done !== 1'b1)
            $display("FAIL cksum_bad: got err=%b done=%b want 1 1", cksum_err, done);
        else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_load_no_stall();
        test_load_stall();
        test_start_ignored();
        test_rst_mid_load();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
